// File: rtl/voq_input_port.sv
// Input port of the crossbar switch: per-destination VOQ occupancy counters,
// a registered request row for the scheduler, and a valid/ready cell dequeue.
module voq_input_port #(
    parameter int number_ports = 4,
    parameter int queue_depth  = 8,
    localparam int dest_width  = (number_ports > 1) ? $clog2(number_ports) : 1,
    localparam int count_width = $clog2(queue_depth + 1),
    localparam int total_width = $clog2(number_ports * queue_depth + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [dest_width-1:0]   in_dest,
    output logic                    in_ready,
    output logic [number_ports-1:0] request,
    input  logic                    grant_valid,
    input  logic [dest_width-1:0]   grant_dest,
    output logic                    deq_valid,
    output logic [dest_width-1:0]   deq_dest,
    input  logic                    deq_ready,
    output logic                    grant_error,
    output logic [total_width-1:0]  total_count
);

    typedef enum logic {IDLE, XFER} state_t;

    localparam logic [count_width-1:0] depth_max = count_width'(queue_depth);
    localparam logic [count_width-1:0] count_one = count_width'(1);

    state_t                  state, state_next;
    logic [count_width-1:0]  count      [number_ports];
    logic [count_width-1:0]  count_next [number_ports];
    logic [number_ports-1:0] nonempty_next;
    logic [number_ports-1:0] request_next;
    logic [total_width-1:0]  total_next;
    logic [dest_width-1:0]   deq_dest_next;
    logic                    grant_error_next;
    logic                    enq, handshake, grant_ok;

    // in_ready looks only at the pre-edge count, so a full VOQ gets no credit
    // from a dequeue happening in the same cycle.
    assign in_ready  = count[in_dest] < depth_max;
    assign enq       = in_valid & in_ready;
    assign handshake = (state == XFER) & deq_ready;
    assign grant_ok  = grant_valid & (state == IDLE) & (count[grant_dest] != '0);

    always_comb begin
        total_next = '0;
        for (int j = 0; j < number_ports; j++) begin
            count_next[j] = count[j];
            if (enq && in_dest == dest_width'(j))
                count_next[j] = count_next[j] + count_one;
            if (handshake && deq_dest == dest_width'(j))
                count_next[j] = count_next[j] - count_one;
            nonempty_next[j] = count_next[j] != '0;
            total_next       = total_next + total_width'(count_next[j]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_ok)  state_next = XFER;
            XFER:    if (deq_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request is held at zero while a cell is in flight and on the grant edge,
    // so the scheduler can never hold two matches for this port.
    always_comb begin
        deq_valid        = (state == XFER);
        request_next     = '0;
        if (state == IDLE && !grant_ok)
            request_next = nonempty_next;
        grant_error_next = grant_valid & ~grant_ok;
        deq_dest_next    = grant_ok ? grant_dest : deq_dest;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < number_ports; j++)
                count[j] <= '0;
            request     <= '0;
            deq_dest    <= '0;
            grant_error <= 1'b0;
            total_count <= '0;
        end else begin
            for (int j = 0; j < number_ports; j++)
                count[j] <= count_next[j];
            request     <= request_next;
            deq_dest    <= deq_dest_next;
            grant_error <= grant_error_next;
            total_count <= total_next;
        end
    end

endmodule

// File: tb/tb_voq_input_port.sv
// Bench for voq_input_port: directed scenarios plus a randomized run, all
// checked against a transaction-level model of the VOQ counters.
module tb_voq_input_port;

    localparam int NP = 4;
    localparam int QD = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [1:0] in_dest;
    logic       in_ready;
    logic [3:0] request;
    logic       grant_valid;
    logic [1:0] grant_dest;
    logic       deq_valid;
    logic [1:0] deq_dest;
    logic       deq_ready;
    logic       grant_error;
    logic [5:0] total_count;

    int total = 0;
    int bad   = 0;

    int         m_count [NP];
    bit         m_busy;
    int         m_dest;
    logic [3:0] m_req;
    bit         m_err;
    int         m_total;

    voq_input_port #(.number_ports(NP), .queue_depth(QD)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_dest(in_dest), .in_ready(in_ready),
        .request(request),
        .grant_valid(grant_valid), .grant_dest(grant_dest),
        .deq_valid(deq_valid), .deq_dest(deq_dest), .deq_ready(deq_ready),
        .grant_error(grant_error), .total_count(total_count)
    );

    always #5 clk = ~clk;

    // Model: one port holding at most one granted cell, counters per destination.
    task automatic model_step();
        bit enq, hs, take;
        if (reset) begin
            foreach (m_count[j]) m_count[j] = 0;
            m_busy = 0; m_dest = 0; m_req = '0; m_err = 0; m_total = 0;
            return;
        end
        enq   = in_valid && (m_count[in_dest] < QD);
        hs    = m_busy && deq_ready;
        take  = grant_valid && !m_busy && (m_count[grant_dest] > 0);
        m_err = grant_valid && !take;
        if (enq) m_count[in_dest]++;
        if (hs)  m_count[m_dest]--;
        m_total = 0;
        foreach (m_count[j]) m_total += m_count[j];
        if (m_busy) begin
            m_req = '0;
            if (hs) m_busy = 0;
        end else if (take) begin
            m_busy = 1; m_dest = grant_dest; m_req = '0;
        end else begin
            foreach (m_count[j]) m_req[j] = (m_count[j] > 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1; in_valid = 0; in_dest = 0; grant_valid = 0; grant_dest = 0; deq_ready = 0;
        tick(); tick();
        reset = 0;
        @(negedge clk);
        total++; if (request !== 4'b0000) begin bad++; $display("[TB] FAIL reset_request got=%b exp=0000", request); end
        total++; if (deq_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_deq_valid got=%b exp=0", deq_valid); end
        total++; if (deq_dest !== 2'd0) begin bad++; $display("[TB] FAIL reset_deq_dest got=%0d exp=0", deq_dest); end
        total++; if (grant_error !== 1'b0) begin bad++; $display("[TB] FAIL reset_grant_error got=%b exp=0", grant_error); end
        total++; if (total_count !== 6'd0) begin bad++; $display("[TB] FAIL reset_total got=%0d exp=0", total_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_enqueue();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_dest = 2;
            tick();
            @(negedge clk);
            total++; if (request !== 4'b0100) begin bad++; $display("[TB] FAIL enq_request[%0d] got=%b exp=0100", i, request); end
            total++; if (total_count !== 6'(i + 1)) begin bad++; $display("[TB] FAIL enq_total[%0d] got=%0d exp=%0d", i, total_count, i + 1); end
        end
        in_valid = 0;
    endtask

    task automatic test_full();
        in_valid = 1; in_dest = 1;
        for (int i = 0; i < QD; i++) tick();
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_in_ready got=%b exp=0", in_ready); end
        tick();
        in_valid = 0;
        @(negedge clk);
        total++; if (total_count !== 6'd11) begin bad++; $display("[TB] FAIL full_total got=%0d exp=11", total_count); end
        in_dest = 0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL other_in_ready got=%b exp=1", in_ready); end
        total++; if (request !== 4'b0110) begin bad++; $display("[TB] FAIL full_request got=%b exp=0110", request); end
    endtask

    task automatic test_xfer();
        grant_valid = 1; grant_dest = 2; deq_ready = 0;
        tick();
        grant_valid = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            deq_ready = (k == 4);
            total++; if (deq_valid !== 1'b1) begin bad++; $display("[TB] FAIL xfer_valid[%0d] got=%b exp=1", k, deq_valid); end
            total++; if (deq_dest !== 2'd2) begin bad++; $display("[TB] FAIL xfer_dest[%0d] got=%0d exp=2", k, deq_dest); end
            total++; if (request !== 4'b0000) begin bad++; $display("[TB] FAIL xfer_request[%0d] got=%b exp=0000", k, request); end
            tick();
        end
        deq_ready = 0;
        @(negedge clk);
        total++; if (deq_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_hs_valid got=%b exp=0", deq_valid); end
        total++; if (request !== 4'b0000) begin bad++; $display("[TB] FAIL post_hs_request got=%b exp=0000", request); end
        total++; if (total_count !== 6'd10) begin bad++; $display("[TB] FAIL post_hs_total got=%0d exp=10", total_count); end
        tick();
        @(negedge clk);
        total++; if (request !== 4'b0110) begin bad++; $display("[TB] FAIL idle_request got=%b exp=0110", request); end
    endtask

    task automatic test_grant_error();
        grant_valid = 1; grant_dest = 3;
        tick();
        grant_valid = 0;
        @(negedge clk);
        total++; if (grant_error !== 1'b1) begin bad++; $display("[TB] FAIL empty_grant_err got=%b exp=1", grant_error); end
        total++; if (deq_valid !== 1'b0) begin bad++; $display("[TB] FAIL empty_grant_valid got=%b exp=0", deq_valid); end
        tick();
        @(negedge clk);
        total++; if (grant_error !== 1'b0) begin bad++; $display("[TB] FAIL empty_grant_pulse got=%b exp=0", grant_error); end
        total++; if (request !== 4'b0110) begin bad++; $display("[TB] FAIL empty_grant_request got=%b exp=0110", request); end
        grant_valid = 1; grant_dest = 1;
        tick();
        grant_dest = 0;
        tick();
        grant_valid = 0;
        @(negedge clk);
        total++; if (grant_error !== 1'b1) begin bad++; $display("[TB] FAIL busy_grant_err got=%b exp=1", grant_error); end
        total++; if (deq_dest !== 2'd1) begin bad++; $display("[TB] FAIL busy_grant_dest got=%0d exp=1", deq_dest); end
        total++; if (deq_valid !== 1'b1) begin bad++; $display("[TB] FAIL busy_grant_valid got=%b exp=1", deq_valid); end
        tick();
        @(negedge clk);
        total++; if (grant_error !== 1'b0) begin bad++; $display("[TB] FAIL busy_grant_pulse got=%b exp=0", grant_error); end
        deq_ready = 1;
        tick();
        deq_ready = 0;
        @(negedge clk);
        total++; if (total_count !== 6'd9) begin bad++; $display("[TB] FAIL busy_grant_total got=%0d exp=9", total_count); end
    endtask

    task automatic test_same_cycle();
        in_valid = 1; in_dest = 0;
        tick();
        in_valid = 0; grant_valid = 1; grant_dest = 0;
        tick();
        grant_valid = 0;
        @(negedge clk);
        total++; if (deq_dest !== 2'd0 || deq_valid !== 1'b1) begin bad++; $display("[TB] FAIL same_xfer got=%b/%0d exp=1/0", deq_valid, deq_dest); end
        deq_ready = 1; in_valid = 1; in_dest = 0;
        tick();
        deq_ready = 0; in_valid = 0;
        @(negedge clk);
        total++; if (total_count !== 6'd10) begin bad++; $display("[TB] FAIL same_total got=%0d exp=10", total_count); end
        tick();
        @(negedge clk);
        total++; if (request !== 4'b0111) begin bad++; $display("[TB] FAIL same_request got=%b exp=0111", request); end
    endtask

    task automatic test_reset_mid_xfer();
        grant_valid = 1; grant_dest = 2;
        tick();
        grant_valid = 0;
        @(negedge clk);
        total++; if (deq_valid !== 1'b1) begin bad++; $display("[TB] FAIL midrst_pre_valid got=%b exp=1", deq_valid); end
        reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        total++; if (deq_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid got=%b exp=0", deq_valid); end
        total++; if (request !== 4'b0000) begin bad++; $display("[TB] FAIL midrst_request got=%b exp=0000", request); end
        total++; if (total_count !== 6'd0) begin bad++; $display("[TB] FAIL midrst_total got=%0d exp=0", total_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            reset       = ($urandom_range(0, 99) == 0);
            in_valid    = ($urandom_range(0, 99) < 60);
            in_dest     = 2'($urandom_range(0, 3));
            grant_valid = ($urandom_range(0, 99) < 30);
            grant_dest  = 2'($urandom_range(0, 3));
            deq_ready   = ($urandom_range(0, 99) < 50);
            #1;
            total++; if (in_ready !== (m_count[in_dest] < QD)) begin bad++; $display("[TB] FAIL rnd_in_ready c=%0d got=%b", c, in_ready); end
            total++; if (request !== m_req) begin bad++; $display("[TB] FAIL rnd_request c=%0d got=%b exp=%b", c, request, m_req); end
            total++; if (deq_valid !== m_busy) begin bad++; $display("[TB] FAIL rnd_deq_valid c=%0d got=%b exp=%b", c, deq_valid, m_busy); end
            total++; if (deq_dest !== 2'(m_dest)) begin bad++; $display("[TB] FAIL rnd_deq_dest c=%0d got=%0d exp=%0d", c, deq_dest, m_dest); end
            total++; if (grant_error !== m_err) begin bad++; $display("[TB] FAIL rnd_grant_error c=%0d got=%b exp=%b", c, grant_error, m_err); end
            total++; if (total_count !== 6'(m_total)) begin bad++; $display("[TB] FAIL rnd_total c=%0d got=%0d exp=%0d", c, total_count, m_total); end
            tick();
        end
        reset = 0; in_valid = 0; grant_valid = 0; deq_ready = 0;
    endtask

    initial begin
        test_reset();
        test_enqueue();
        test_full();
        test_xfer();
        test_grant_error();
        test_same_cycle();
        test_reset_mid_xfer();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
